// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types: the machine word, the RAM handshake state reported by the
// memory, and the state encoding of the instruction/data RAM arbiter.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the single-port RAM for the access currently strobed.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter states: one transaction in flight, data side has priority.
    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_DREQ = 3'd1,
        ARB_IREQ = 3'd2,
        ARB_DHIT = 3'd3,
        ARB_IHIT = 3'd4,
        ARB_ERR  = 3'd5
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;
    localparam int unsigned ARB_CNT_W_DEFAULT   = 7;

endpackage

// File: rtl/arb_timeout_counter.sv
// ----------------------------------------------------------------------------
// arb_timeout_counter
// Counts cycles spent waiting on one RAM access and flags when the count has
// reached LIMIT-1, i.e. the access has been outstanding for LIMIT cycles.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clear    in  force the count to zero (wins over enable)
//   enable   in  advance the count by one
//   expired  out count == LIMIT-1
// ----------------------------------------------------------------------------
module arb_timeout_counter #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Serialises instruction-fetch and data requests onto a single RAM port and
// returns one-cycle ihit/dhit pulses. Data requests win on a tie; only one
// transaction is in flight. All outputs are registered.
// Ports:
//   CLK, nRST                 clock / asynchronous active-low reset
//   iREN, iaddr               instruction read request (level) and address
//   iload, ihit               fetched word and completion pulse
//   dREN, dWEN, daddr, dstore data read/write request (level), address, data
//   dload, dhit               read data and completion pulse
//   ramREN, ramWEN, ramaddr,  RAM strobes, address and write data
//   ramstore
//   ramload, ramstate         RAM read data and handshake status
//   mem_err                   sticky error (RAM ERROR or access timeout)
// ----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = ARB_CNT_W_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    arb_state_t state_q, state_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    logic       wr_q, wr_d;
    logic       abandon_q, abandon_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       ihit_q, ihit_d;
    logic       dhit_q, dhit_d;
    logic       ram_ren_q, ram_ren_d;
    logic       ram_wen_q, ram_wen_d;
    word_t      ram_addr_q, ram_addr_d;
    word_t      ram_store_q, ram_store_d;
    logic       mem_err_q, mem_err_d;

    logic in_req;
    logic access;
    logic expired;

    assign in_req = (state_q == ARB_DREQ) || (state_q == ARB_IREQ);
    assign access = (ramstate == ACCESS);

    // Count only while waiting on the RAM; clear on completion so the next
    // access starts from zero.
    arb_timeout_counter #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (nRST),
        .clear   (!in_req || access),
        .enable  (in_req),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        abandon_d = abandon_q;
        iload_d   = iload_q;
        dload_d   = dload_q;

        case (state_q)
            ARB_IDLE: begin
                if (dREN || dWEN) begin
                    // A request with both strobes set is treated as a write.
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                    state_d = ARB_DREQ;
                end else if (iREN) begin
                    addr_d    = iaddr;
                    store_d   = '0;
                    wr_d      = 1'b0;
                    abandon_d = 1'b0;
                    state_d   = ARB_IREQ;
                end
            end
            ARB_DREQ, ARB_IREQ: begin
                // A fetch whose requester has gone away still finishes on the
                // RAM, but its hit pulse is withheld.
                if ((state_q == ARB_IREQ) && !iREN) begin
                    abandon_d = 1'b1;
                end
                if (ramstate == ERROR) begin
                    state_d = ARB_ERR;
                end else if (access) begin
                    if (state_q == ARB_IREQ) begin
                        iload_d = ramload;
                        state_d = ARB_IHIT;
                    end else begin
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                        state_d = ARB_DHIT;
                    end
                end else if (expired) begin
                    state_d = ARB_ERR;
                end
            end
            ARB_DHIT, ARB_IHIT: state_d = ARB_IDLE;
            ARB_ERR:            state_d = ARB_ERR;
            default:            state_d = ARB_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it
        // once registered; the RAM only ever sees the latched request.
        ram_ren_d   = ((state_d == ARB_DREQ) && !wr_d) || (state_d == ARB_IREQ);
        ram_wen_d   = (state_d == ARB_DREQ) && wr_d;
        ram_addr_d  = ((state_d == ARB_DREQ) || (state_d == ARB_IREQ)) ? addr_d : '0;
        ram_store_d = ram_wen_d ? store_d : '0;
        dhit_d      = (state_d == ARB_DHIT);
        ihit_d      = (state_d == ARB_IHIT) && !abandon_d;
        mem_err_d   = (state_d == ARB_ERR);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ARB_IDLE;
            addr_q      <= '0;
            store_q     <= '0;
            wr_q        <= 1'b0;
            abandon_q   <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            wr_q        <= wr_d;
            abandon_q   <= abandon_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ram_addr_q;
    assign ramstore = ram_store_q;
    assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboarded bench for mem_arbiter with a behavioural single-port RAM that
// answers BUSY for a programmable number of cycles, then ACCESS.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // ---------------- behavioural RAM ----------------
    logic [31:0] mem [0:255];
    bit          mem_init_done = 1'b0;
    int          ram_cnt = 0;
    int          busy_cycles = 0;
    bit          hang = 1'b0;
    bit          force_err = 1'b0;
    logic        strobe;

    assign strobe  = ramREN | ramWEN;
    assign ramload = mem[ramaddr[9:2]];

    always_comb begin
        ramstate = FREE;
        if (strobe) begin
            if (force_err)                          ramstate = ERROR;
            else if (!hang && ram_cnt >= busy_cycles) ramstate = ACCESS;
            else                                    ramstate = BUSY;
        end
    end

    always @(posedge CLK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[16]  <= 32'h2402000A;   // 0x40
            mem[17]  <= 32'h00851020;   // 0x44
            mem[32]  <= 32'h11111111;   // 0x80
            mem[64]  <= 32'h8C220004;   // 0x100
            mem_init_done <= 1'b1;
        end else begin
            if (strobe && ramstate == ACCESS && ramWEN) mem[ramaddr[9:2]] <= ramstore;
        end
        if (strobe && ramstate != ACCESS) ram_cnt <= ram_cnt + 1;
        else                              ram_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] store;
    } ram_exp_t;

    typedef struct {
        logic        is_i;
        logic [31:0] data;
    } hit_exp_t;

    ram_exp_t ram_q[$];
    hit_exp_t hit_q[$];
    ram_exp_t re;
    hit_exp_t he;

    always @(negedge CLK) begin
        if (nRST) begin
            if (ramstate == ACCESS) begin
                if (ram_q.size() == 0) begin
                    check_val("ram_unexpected", 32'(ramaddr), 32'hFFFFFFFF);
                end else begin
                    re = ram_q.pop_front();
                    check_val("ram_addr", ramaddr, re.addr);
                    check_val("ram_wen", 32'(ramWEN), 32'(re.wen));
                    if (re.wen) check_val("ram_store", ramstore, re.store);
                end
            end
            if (ihit || dhit) begin
                if (ihit && dhit) check_val("dual_hit", 32'(1), 32'(0));
                if (hit_q.size() == 0) begin
                    check_val("hit_unexpected", 32'(ihit), 32'(0));
                end else begin
                    he = hit_q.pop_front();
                    check_val("hit_kind", 32'(ihit), 32'(he.is_i));
                    check_val("hit_data", ihit ? iload : dload, he.data);
                end
            end
        end
    end

    task automatic push_ram(input logic [31:0] a, input logic w, input logic [31:0] s);
        ram_exp_t e;
        e.addr = a; e.wen = w; e.store = s;
        ram_q.push_back(e);
    endtask

    task automatic push_hit(input logic i, input logic [31:0] d);
        hit_exp_t e;
        e.is_i = i; e.data = d;
        hit_q.push_back(e);
    endtask

    // Waits for the requested hit, drops that request on the hit cycle and
    // returns the number of falling edges it took.
    task automatic wait_hit(input bit want_i, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < 30) begin
            @(negedge CLK);
            n++;
            if (want_i ? ihit : dhit) begin
                got = 1'b1;
                if (want_i) iREN = 1'b0;
                else begin
                    dREN = 1'b0;
                    dWEN = 1'b0;
                end
            end
        end
        if (!got) check_val("hit_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0;
        repeat (2) @(negedge CLK);
        check_val("rst_outs", {26'b0, ihit, dhit, ramREN, ramWEN, mem_err, 1'b0}, 32'h0);
        check_val("rst_ramaddr", ramaddr, 32'h0);
        check_val("rst_iload", iload, 32'h0);
        check_val("rst_dload", dload, 32'h0);
        nRST = 1'b1;

        // 1: fetch with two BUSY cycles
        @(negedge CLK);
        busy_cycles = 2;
        iaddr = 32'h40; iREN = 1'b1;
        push_ram(32'h40, 1'b0, 32'h0);
        push_hit(1'b1, 32'h2402000A);
        @(negedge CLK);
        check_val("t1_ireq_addr", ramaddr, 32'h40);
        check_val("t1_ireq_ren", 32'(ramREN), 32'(1));
        wait_hit(1'b1, n);
        check_val("t1_latency", 32'(n), 32'(3));
        @(negedge CLK);
        check_val("t1_ihit_pulse", 32'(ihit), 32'(0));
        check_val("t1_iload_hold", iload, 32'h2402000A);

        // 2: simultaneous requests, data first
        busy_cycles = 1;
        daddr = 32'h100; iaddr = 32'h44; dREN = 1'b1; iREN = 1'b1;
        push_ram(32'h100, 1'b0, 32'h0);
        push_ram(32'h44, 1'b0, 32'h0);
        push_hit(1'b0, 32'h8C220004);
        push_hit(1'b1, 32'h00851020);
        wait_hit(1'b0, n);
        check_val("t2_d_latency", 32'(n), 32'(3));
        wait_hit(1'b1, n);
        check_val("t2_i_latency", 32'(n), 32'(4));

        // 3: write, dload unchanged, then read back
        busy_cycles = 0;
        daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1'b1;
        push_ram(32'h200, 1'b1, 32'hDEADBEEF);
        push_hit(1'b0, 32'h8C220004);
        wait_hit(1'b0, n);
        check_val("t3_w_latency", 32'(n), 32'(3));
        daddr = 32'h200; dREN = 1'b1;
        push_ram(32'h200, 1'b0, 32'h0);
        push_hit(1'b0, 32'hDEADBEEF);
        wait_hit(1'b0, n);
        check_val("t3_r_latency", 32'(n), 32'(3));

        // 4: abandoned fetch, then a data read
        busy_cycles = 3;
        iaddr = 32'h80; iREN = 1'b1;
        push_ram(32'h80, 1'b0, 32'h0);
        repeat (2) @(negedge CLK);
        iREN = 1'b0;
        k = 0;
        while (ramstate != ACCESS && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check_val("t4_access_seen", 32'(ramstate), 32'(ACCESS));
        busy_cycles = 0;
        daddr = 32'h100; dREN = 1'b1;
        push_ram(32'h100, 1'b0, 32'h0);
        push_hit(1'b0, 32'h8C220004);
        @(negedge CLK);
        check_val("t4_abandon_ihit", 32'(ihit), 32'(0));
        wait_hit(1'b0, n);
        check_val("t4_d_latency", 32'(n), 32'(3));

        // 5a: timeout with RAM stuck BUSY
        hang = 1'b1;
        iaddr = 32'h40; iREN = 1'b1;
        repeat (65) @(negedge CLK);
        check_val("t5_pre_err", 32'(mem_err), 32'(0));
        check_val("t5_pre_ren", 32'(ramREN), 32'(1));
        @(negedge CLK);
        check_val("t5_timeout_err", 32'(mem_err), 32'(1));
        check_val("t5_err_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        check_val("t5_err_addr", ramaddr, 32'h0);
        iREN = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("t5_err_sticky", 32'(mem_err), 32'(1));
        nRST = 1'b0;
        @(negedge CLK);
        check_val("t5_err_cleared", 32'(mem_err), 32'(0));
        nRST = 1'b1;
        hang = 1'b0;

        // 5b: RAM reports ERROR
        force_err = 1'b1;
        daddr = 32'h100; dREN = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("t5_ramerr_err", 32'(mem_err), 32'(1));
        check_val("t5_ramerr_outs", {29'b0, ramREN, ramWEN, dhit}, 32'h0);
        dREN = 1'b0;
        force_err = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // 6: async reset mid DREQ, then a fresh request
        hang = 1'b1;
        daddr = 32'h200; dREN = 1'b1;
        @(negedge CLK);
        check_val("t6_dreq_ren", 32'(ramREN), 32'(1));
        #2 nRST = 1'b0;
        #1;
        check_val("t6_rst_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        check_val("t6_rst_addr", ramaddr, 32'h0);
        check_val("t6_rst_dload", dload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        hang = 1'b0;
        push_ram(32'h200, 1'b0, 32'h0);
        push_hit(1'b0, 32'hDEADBEEF);
        wait_hit(1'b0, n);
        check_val("t6_min_latency", 32'(n), 32'(2));

        repeat (2) @(negedge CLK);
        check_val("ram_q_empty", 32'(ram_q.size()), 32'(0));
        check_val("hit_q_empty", 32'(hit_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
